tcam_lookup_ctrl: RTL and testbench

Request-side controller that acts as the sole initiator of a 16-entry x 16-bit TCAM. Accepts lookup, lookup-and-learn, and direct-write commands over a valid/ready request channel. Sequences the TCAM's write/search pins, captures the registered match result, and returns one response per command over a valid/ready response channel. On a learning miss, it inserts the key at a round-robin victim slot and keeps saturating hit/miss statistics.

---
 rtl/tcam_pkg.sv | 22 ++
 rtl/tcam_sat_cnt.sv | 23 ++
 rtl/tcam_lookup_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_tcam_lookup_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM lookup controller: FSM states, command op codes
// and default geometry of the attached 16-entry TCAM.
package tcam_pkg;

  localparam int DEF_KEY_W  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int TCAM_DEPTH = 16;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_LEARN  = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_RESULT,
    ST_LEARN,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/tcam_sat_cnt.sv
// Saturating up-counter used for the hit/miss statistics; sticks at all-ones.
module tcam_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tcam_lookup_ctrl.sv
// Sole initiator of a 16x16 TCAM: sequences search/write pins per command, learns
// missing keys into a round-robin victim slot and returns one response per command.
//
// state  | meaning
// IDLE   | ready for a command, latches op/key/addr on accept
// SEARCH | search strobe up, TCAM any-match captured into hit_q
// RESULT | search held, registered TCAM index/data captured, stats updated
// LEARN  | miss insertion of the key at the victim slot
// WRITE  | direct write of the key at the requested address
// RESP   | response presented and held until consumed
module tcam_lookup_ctrl
  import tcam_pkg::*;
#(
  parameter int KEY_W  = DEF_KEY_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [KEY_W-1:0]  req_key,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_learned,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [KEY_W-1:0]  rsp_data,
  output logic              t_we,
  output logic              t_search,
  output logic [ADDR_W-1:0] t_waddr,
  output logic [KEY_W-1:0]  t_data,
  input  logic [ADDR_W-1:0] t_saddr,
  input  logic [KEY_W-1:0]  t_sdata,
  input  logic              t_found,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] victim_q, victim_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              rsp_learned_q, rsp_learned_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [KEY_W-1:0]  rsp_data_q, rsp_data_d;
  logic              hit_inc, miss_inc;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_LOOKUP;
      key_q         <= '0;
      addr_q        <= '0;
      hit_q         <= 1'b0;
      victim_q      <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_learned_q <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      key_q         <= key_d;
      addr_q        <= addr_d;
      hit_q         <= hit_d;
      victim_q      <= victim_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_learned_q <= rsp_learned_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    key_d         = key_q;
    addr_d        = addr_q;
    hit_d         = hit_q;
    victim_d      = victim_q;
    rsp_hit_d     = rsp_hit_q;
    rsp_learned_d = rsp_learned_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_data_d    = rsp_data_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    t_we          = 1'b0;
    t_search      = 1'b0;
    t_waddr       = '0;
    t_data        = '0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          key_d   = req_key;
          addr_d  = req_addr;
          state_d = (req_op == OP_WRITE) ? ST_WRITE : ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        t_search = 1'b1;
        t_data   = key_q;
        hit_d    = t_found;
        state_d  = ST_RESULT;
      end
      ST_RESULT: begin
        // t_saddr/t_sdata were registered by the TCAM on the SEARCH edge
        t_search = 1'b1;
        t_data   = key_q;
        if (hit_q) begin
          hit_inc       = 1'b1;
          rsp_hit_d     = 1'b1;
          rsp_learned_d = 1'b0;
          rsp_addr_d    = t_saddr;
          rsp_data_d    = t_sdata;
          state_d       = ST_RESP;
        end else begin
          miss_inc      = 1'b1;
          rsp_hit_d     = 1'b0;
          rsp_learned_d = 1'b0;
          rsp_addr_d    = '0;
          rsp_data_d    = '0;
          state_d       = (op_q == OP_LEARN) ? ST_LEARN : ST_RESP;
        end
      end
      ST_LEARN: begin
        t_we          = 1'b1;
        t_waddr       = victim_q;
        t_data        = key_q;
        rsp_hit_d     = 1'b0;
        rsp_learned_d = 1'b1;
        rsp_addr_d    = victim_q;
        rsp_data_d    = key_q;
        victim_d      = (victim_q == ADDR_W'(TCAM_DEPTH - 1)) ? '0 : victim_q + ADDR_W'(1);
        state_d       = ST_RESP;
      end
      ST_WRITE: begin
        t_we          = 1'b1;
        t_waddr       = addr_q;
        t_data        = key_q;
        rsp_hit_d     = 1'b0;
        rsp_learned_d = 1'b0;
        rsp_addr_d    = addr_q;
        rsp_data_d    = key_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_hit_d     = 1'b0;
          rsp_learned_d = 1'b0;
          rsp_addr_d    = '0;
          rsp_data_d    = '0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_hit     = rsp_hit_q;
  assign rsp_learned = rsp_learned_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_data    = rsp_data_q;

  tcam_sat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk  (clk),
    .rstN (rstN),
    .inc  (hit_inc),
    .cnt  (hit_cnt)
  );

  tcam_sat_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk  (clk),
    .rstN (rstN),
    .inc  (miss_inc),
    .cnt  (miss_cnt)
  );

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Directed bench for tcam_lookup_ctrl with a behavioural 16x16 exact-match TCAM.
module tb_tcam_lookup_ctrl;
  import tcam_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_key;
  logic [3:0]  req_addr;
  logic        rsp_valid, rsp_ready, rsp_hit, rsp_learned;
  logic [3:0]  rsp_addr;
  logic [15:0] rsp_data;
  logic        t_we, t_search, t_found;
  logic [3:0]  t_waddr;
  logic [15:0] t_data;
  logic [3:0]  t_saddr = '0;
  logic [15:0] t_sdata = '0;
  logic [15:0] hit_cnt, miss_cnt;

  logic [15:0] mem   [16] = '{default: 16'h0000};
  logic        mem_v [16] = '{default: 1'b0};
  logic [3:0]  m_idx;

  int n_chk = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  int          r_lat;
  logic        r_hit, r_learned, r_idle;
  logic [3:0]  r_addr;
  logic [15:0] r_data;
  logic [31:0] snap;

  always #5 clk = ~clk;

  tcam_lookup_ctrl dut (
    .clk(clk), .rstN(rstN),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_learned(rsp_learned), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .t_we(t_we), .t_search(t_search), .t_waddr(t_waddr), .t_data(t_data),
    .t_saddr(t_saddr), .t_sdata(t_sdata), .t_found(t_found),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // TCAM model: combinational any-match, registered lowest matching index
  always_comb begin
    t_found = 1'b0;
    m_idx   = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mem_v[i] && (mem[i] == t_data)) begin
        t_found = 1'b1;
        m_idx   = 4'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (t_we) begin
      mem[t_waddr]   <= t_data;
      mem_v[t_waddr] <= 1'b1;
    end
    if (t_search) begin
      t_saddr <= m_idx;
      t_sdata <= mem[m_idx];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] key, input logic [3:0] addr);
    @(negedge clk);
    req_op = op; req_key = key; req_addr = addr; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 0;
    while (!rsp_valid && r_lat < 20) begin
      @(posedge clk);
      #1 r_lat++;
    end
    r_hit = rsp_hit; r_learned = rsp_learned; r_addr = rsp_addr; r_data = rsp_data;
    @(posedge clk);
    #1 r_idle = req_ready && !rsp_valid;
  endtask

  task automatic expect_rsp(input string tag, input int lat, input logic hit,
                            input logic learned, input logic [3:0] addr, input logic [15:0] data);
    chk({tag, "_lat"}, 32'(r_lat), 32'(lat));
    chk({tag, "_hit"}, 32'(r_hit), 32'(hit));
    chk({tag, "_learned"}, 32'(r_learned), 32'(learned));
    chk({tag, "_addr"}, 32'(r_addr), 32'(addr));
    chk({tag, "_data"}, 32'(r_data), 32'(data));
    chk({tag, "_idle"}, 32'(r_idle), 32'd1);
    chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(exp_miss));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp"}, {11'd0, rsp_valid, rsp_hit, rsp_learned, rsp_addr, rsp_data}, 32'd0);
    chk({tag, "_tpins"}, {10'd0, t_we, t_search, t_waddr, t_data}, 32'd0);
    chk({tag, "_cnts"}, {hit_cnt, miss_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rstN = 1'b0; req_valid = 1'b0; req_op = '0; req_key = '0; req_addr = '0; rsp_ready = 1'b1;
    #12 chk_reset_outputs("reset");
    @(negedge clk) rstN = 1'b1;

    // plain miss
    run_cmd(OP_LOOKUP, 16'hABCD, 4'd0);
    exp_miss++;
    expect_rsp("miss_abcd", 2, 1'b0, 1'b0, 4'd0, 16'h0000);

    // write then lookup same key
    run_cmd(OP_WRITE, 16'h1234, 4'd5);
    expect_rsp("wr_1234", 1, 1'b0, 1'b0, 4'd5, 16'h1234);
    chk("wr_1234_entry", {15'd0, mem_v[5], mem[5]}, {15'd0, 1'b1, 16'h1234});
    run_cmd(OP_LOOKUP, 16'h1234, 4'd0);
    exp_hit++;
    expect_rsp("hit_1234", 2, 1'b1, 1'b0, 4'd5, 16'h1234);

    // 17 learns: victim walks 0..15 then wraps to 0
    for (int i = 0; i < 17; i++) begin
      run_cmd(OP_LEARN, 16'h0100 + 16'(i), 4'd0);
      exp_miss++;
      expect_rsp($sformatf("learn_%0d", i), 3, 1'b0, 1'b1, 4'(i % 16), 16'h0100 + 16'(i));
    end
    run_cmd(OP_LOOKUP, 16'h0100, 4'd0);
    exp_miss++;
    expect_rsp("evicted_0100", 2, 1'b0, 1'b0, 4'd0, 16'h0000);
    run_cmd(OP_LOOKUP, 16'h0101, 4'd0);
    exp_hit++;
    expect_rsp("hit_0101", 2, 1'b1, 1'b0, 4'd1, 16'h0101);
    run_cmd(OP_LEARN, 16'h0110, 4'd0);
    exp_hit++;
    expect_rsp("learn_hit_0110", 2, 1'b1, 1'b0, 4'd0, 16'h0110);

    // op 11 behaves as a lookup, never learns
    run_cmd(2'b11, 16'h0104, 4'd0);
    exp_hit++;
    expect_rsp("op3_hit", 2, 1'b1, 1'b0, 4'd4, 16'h0104);
    run_cmd(2'b11, 16'h5555, 4'd0);
    exp_miss++;
    expect_rsp("op3_miss", 2, 1'b0, 1'b0, 4'd0, 16'h0000);

    // duplicate key: lowest index wins
    run_cmd(OP_WRITE, 16'h00FF, 4'd9);
    expect_rsp("wr_ff_9", 1, 1'b0, 1'b0, 4'd9, 16'h00FF);
    run_cmd(OP_WRITE, 16'h00FF, 4'd3);
    expect_rsp("wr_ff_3", 1, 1'b0, 1'b0, 4'd3, 16'h00FF);
    run_cmd(OP_LOOKUP, 16'h00FF, 4'd0);
    exp_hit++;
    expect_rsp("lowest_ff", 2, 1'b1, 1'b0, 4'd3, 16'h00FF);

    // response backpressure with a pending request
    @(negedge clk);
    rsp_ready = 1'b0;
    req_op = OP_LOOKUP; req_key = 16'h00FF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_op = OP_WRITE; req_key = 16'hDEAD; req_addr = 4'd7;
    r_lat = 0;
    while (!rsp_valid && r_lat < 20) begin
      @(posedge clk);
      #1 r_lat++;
    end
    exp_hit++;
    chk("stall_lat", 32'(r_lat), 32'd2);
    snap = {11'd0, rsp_valid, rsp_hit, rsp_learned, rsp_addr, rsp_data};
    chk("stall_first_rsp", snap, {11'd0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h00FF});
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_rsp_%0d", c), {11'd0, rsp_valid, rsp_hit, rsp_learned, rsp_addr, rsp_data}, snap);
      chk($sformatf("stall_pins_%0d", c), {29'd0, req_ready, t_we, t_search}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("stall_release_idle", {30'd0, req_ready, rsp_valid}, 32'b10);
    chk("stall_no_write", 32'(mem[7]), 32'h0107);
    chk("stall_hit_cnt", 32'(hit_cnt), 32'(exp_hit));

    // async reset in LEARN: victim would be 1 here
    @(negedge clk);
    req_op = OP_LEARN; req_key = 16'h7777; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 chk("learn_pre_reset", {27'd0, t_we, t_waddr}, {27'd0, 1'b1, 4'd1});
    rstN = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 chk("reset_no_write", 32'(mem[1]), 32'h0101);
    @(negedge clk) rstN = 1'b1;
    exp_hit = 0; exp_miss = 0;

    // victim restarts at 0 after reset
    run_cmd(OP_LEARN, 16'h8888, 4'd0);
    exp_miss++;
    expect_rsp("post_reset_learn", 3, 1'b0, 1'b1, 4'd0, 16'h8888);
    run_cmd(OP_LOOKUP, 16'h8888, 4'd0);
    exp_hit++;
    expect_rsp("post_reset_hit", 2, 1'b1, 1'b0, 4'd0, 16'h8888);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
